// File: rtl/v2f_pkg.sv
// Shared types and helpers for the v2f sequential divider.
package v2f_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned v2f_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/v2f_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit,
// subtract the divisor when it fits.
module v2f_div_step #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_div,
    input  logic         i_bit,
    output logic [W-1:0] o_rem_c,
    output logic         o_q_c
);

    logic [W:0] w_shift;
    logic [W:0] w_diff;

    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_div};
        o_q_c   = (w_shift >= {1'b0, i_div});
        o_rem_c = o_q_c ? w_diff[W-1:0] : w_shift[W-1:0];
    end

endmodule

// File: rtl/v2f_div_seq.sv
// Fixed-latency sequential divider: capture, W restoring steps on magnitudes,
// then one sign fix-up cycle; result held until the consumer accepts it.
module v2f_div_seq
    import v2f_pkg::*;
#(
    parameter int unsigned A_WIDTH  = 8,
    parameter int unsigned B_WIDTH  = 8,
    parameter int unsigned Y_WIDTH  = 8,
    parameter bit          A_SIGNED = 1'b0,
    parameter bit          B_SIGNED = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [Y_WIDTH-1:0] Y,
    output logic [Y_WIDTH-1:0] R,
    output logic               DZ,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);

    localparam int unsigned W     = v2f_max(A_WIDTH, B_WIDTH);
    localparam int unsigned CW    = $clog2(W + 1);
    localparam bit          SMODE = A_SIGNED && B_SIGNED;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_quo;
    logic [W-1:0]   r_div;
    logic [W-1:0]   r_a_ext;
    logic           r_q_neg;
    logic           r_r_neg;
    logic           r_dz;
    logic [Y_WIDTH-1:0] r_y;
    logic [Y_WIDTH-1:0] r_r;
    logic           r_dz_o;
    logic           r_in_ready;
    logic           r_out_valid;

    logic           w_accept;
    logic           w_step;
    logic           w_finish;
    logic [W-1:0]   w_a_ext;
    logic [W-1:0]   w_b_ext;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [W-1:0]   w_rem_nxt;
    logic           w_q_bit;
    logic [W-1:0]   w_q_fix;
    logic [W-1:0]   w_r_fix;
    logic [Y_WIDTH-1:0] w_y_res;
    logic [Y_WIDTH-1:0] w_r_res;

    // Operand extension to the common width and magnitude conversion
    always_comb begin
        w_a_ext = A_SIGNED ? W'(signed'(A)) : W'(A);
        w_b_ext = B_SIGNED ? W'(signed'(B)) : W'(B);
        w_a_neg = SMODE && w_a_ext[W-1];
        w_b_neg = SMODE && w_b_ext[W-1];
        w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
    end

    v2f_div_step #(.W(W)) u_step (
        .i_rem   (r_rem),
        .i_div   (r_div),
        .i_bit   (r_quo[W-1]),
        .o_rem_c (w_rem_nxt),
        .o_q_c   (w_q_bit)
    );

    // Sign fix-up; most-negative / -1 wraps naturally through the negation
    always_comb begin
        w_q_fix = r_q_neg ? -r_quo : r_quo;
        w_r_fix = r_r_neg ? -r_rem : r_rem;
        if (SMODE) begin
            w_y_res = Y_WIDTH'(signed'(w_q_fix));
            w_r_res = Y_WIDTH'(signed'(w_r_fix));
        end else begin
            w_y_res = Y_WIDTH'(w_q_fix);
            w_r_res = Y_WIDTH'(w_r_fix);
        end
        if (r_dz) begin
            w_y_res = '1;
            w_r_res = A_SIGNED ? Y_WIDTH'(signed'(r_a_ext)) : Y_WIDTH'(r_a_ext);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (IN_VALID) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == CW'(W)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_a_ext     <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dz        <= 1'b0;
            r_y         <= '0;
            r_r         <= '0;
            r_dz_o      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                r_quo   <= w_a_mag;
                r_div   <= w_b_mag;
                r_a_ext <= w_a_ext;
                r_q_neg <= w_a_neg ^ w_b_neg;
                r_r_neg <= w_a_neg;
                r_dz    <= (w_b_ext == '0);
            end
            // Dividend shifts out the top while quotient bits enter at the bottom
            if (w_step) begin
                r_cnt <= r_cnt + CW'(1);
                r_rem <= w_rem_nxt;
                r_quo <= W'({r_quo, w_q_bit});
            end
            if (w_finish) begin
                r_y    <= w_y_res;
                r_r    <= w_r_res;
                r_dz_o <= r_dz;
            end
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign Y         = r_y;
    assign R         = r_r;
    assign DZ        = r_dz_o;

endmodule

// File: tb/tb_v2f_div_seq.sv
// Directed bench for v2f_div_seq: unsigned 8-bit, signed 8-bit and 16/4/16 instances.
module tb_v2f_div_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  a0, b0, y0, r0;
    logic [7:0]  a1, b1, y1, r1;
    logic [15:0] a2, y2, r2;
    logic [3:0]  b2;
    logic iv0, iv1, iv2, ir0, ir1, ir2, ov0, ov1, ov2;
    logic dz0, dz1, dz2, ordy0, ordy1, ordy2;

    int errors = 0;
    int checks = 0;

    v2f_div_seq #(.A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(8), .A_SIGNED(1'b0), .B_SIGNED(1'b0)) u_u8 (
        .CLK(clk), .RST(rst), .A(a0), .B(b0), .IN_VALID(iv0), .IN_READY(ir0),
        .Y(y0), .R(r0), .DZ(dz0), .OUT_VALID(ov0), .OUT_READY(ordy0));

    v2f_div_seq #(.A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(8), .A_SIGNED(1'b1), .B_SIGNED(1'b1)) u_s8 (
        .CLK(clk), .RST(rst), .A(a1), .B(b1), .IN_VALID(iv1), .IN_READY(ir1),
        .Y(y1), .R(r1), .DZ(dz1), .OUT_VALID(ov1), .OUT_READY(ordy1));

    v2f_div_seq #(.A_WIDTH(16), .B_WIDTH(4), .Y_WIDTH(16), .A_SIGNED(1'b0), .B_SIGNED(1'b0)) u_m16 (
        .CLK(clk), .RST(rst), .A(a2), .B(b2), .IN_VALID(iv2), .IN_READY(ir2),
        .Y(y2), .R(r2), .DZ(dz2), .OUT_VALID(ov2), .OUT_READY(ordy2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic f_ov(input int k);
        case (k)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic f_ir(input int k);
        case (k)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic f_dz(input int k);
        case (k)
            0:       return dz0;
            1:       return dz1;
            default: return dz2;
        endcase
    endfunction

    function automatic logic [15:0] f_y(input int k);
        case (k)
            0:       return {8'h00, y0};
            1:       return {8'h00, y1};
            default: return y2;
        endcase
    endfunction

    function automatic logic [15:0] f_r(input int k);
        case (k)
            0:       return {8'h00, r0};
            1:       return {8'h00, r1};
            default: return r2;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic [15:0] a, input logic [15:0] b, input logic v);
        case (k)
            0:       begin a0 = a[7:0]; b0 = b[7:0]; iv0 = v; end
            1:       begin a1 = a[7:0]; b1 = b[7:0]; iv1 = v; end
            default: begin a2 = a;      b2 = b[3:0]; iv2 = v; end
        endcase
    endtask

    task automatic set_ordy(input int k, input logic v);
        case (k)
            0:       ordy0 = v;
            1:       ordy1 = v;
            default: ordy2 = v;
        endcase
    endtask

    // Present operands for one accepting edge, then scramble them
    task automatic start(input int k, input logic [15:0] a, input logic [15:0] b);
        drive(k, a, b, 1'b1);
        tick();
        drive(k, ~a, ~b, 1'b0);
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!f_ov(k) && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ey, input logic [15:0] er, input logic edz,
                         input int elat, input string tag);
        int lat;
        start(k, a, b);
        wait_valid(k, lat);
        chk({tag, " lat"}, 32'(lat), 32'(elat));
        chk({tag, " y"},   32'(f_y(k)), 32'(ey));
        chk({tag, " r"},   32'(f_r(k)), 32'(er));
        chk({tag, " dz"},  32'(f_dz(k)), 32'(edz));
        set_ordy(k, 1'b1);
        tick();
        set_ordy(k, 1'b0);
        chk({tag, " idle"}, 32'(f_ir(k)), 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [15:0] ra;
        logic [3:0]  rb;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(k, 16'h0, 16'h0, 1'b0);
            set_ordy(k, 1'b0);
        end
        tick();
        tick();
        rst = 1'b0;
        chk("rst in_ready",  32'(ir0), 32'd1);
        chk("rst out_valid", 32'(ov0), 32'd0);
        chk("rst y",         32'(y0),  32'd0);
        chk("rst r",         32'(r0),  32'd0);
        chk("rst dz",        32'(dz0), 32'd0);

        // Unsigned 8-bit
        do_op(0, 16'd200,  16'd7,  16'd28,  16'd4,  1'b0, 9, "u8 200/7");
        do_op(0, 16'h5A,   16'd0,  16'hFF,  16'h5A, 1'b1, 9, "u8 5a/0");
        do_op(0, 16'd255,  16'd1,  16'd255, 16'd0,  1'b0, 9, "u8 255/1");
        do_op(0, 16'd5,    16'd10, 16'd0,   16'd5,  1'b0, 9, "u8 5/10");

        // Signed 8-bit
        do_op(1, 16'hF9, 16'h02, 16'hFD, 16'hFF, 1'b0, 9, "s8 -7/2");
        do_op(1, 16'h80, 16'hFF, 16'h80, 16'h00, 1'b0, 9, "s8 -128/-1");
        do_op(1, 16'h07, 16'hFE, 16'hFD, 16'h01, 1'b0, 9, "s8 7/-2");
        do_op(1, 16'hF8, 16'hFD, 16'h02, 16'hFE, 1'b0, 9, "s8 -8/-3");
        do_op(1, 16'h7F, 16'h80, 16'h00, 16'h7F, 1'b0, 9, "s8 127/-128");
        do_op(1, 16'hFB, 16'h00, 16'hFF, 16'hFB, 1'b1, 9, "s8 -5/0");

        // Backpressure: result held, inputs ignored while in DONE
        start(0, 16'd100, 16'd9);
        wait_valid(0, lat);
        chk("bp lat", 32'(lat), 32'd9);
        for (int i = 0; i < 5; i++) begin
            drive(0, 16'h33, 16'h02, 1'b1);
            tick();
            chk("bp y",         32'(y0),  32'd11);
            chk("bp r",         32'(r0),  32'd1);
            chk("bp dz",        32'(dz0), 32'd0);
            chk("bp out_valid", 32'(ov0), 32'd1);
            chk("bp in_ready",  32'(ir0), 32'd0);
        end
        drive(0, 16'h0, 16'h0, 1'b0);
        set_ordy(0, 1'b1);
        tick();
        set_ordy(0, 1'b0);
        chk("bp drain out_valid", 32'(ov0), 32'd0);
        chk("bp drain in_ready",  32'(ir0), 32'd1);
        tick();
        chk("bp no stale accept", 32'(ir0), 32'd1);

        // Reset during CALC discards the operation
        start(0, 16'd200, 16'd7);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst in_ready",  32'(ir0), 32'd1);
        chk("midrst out_valid", 32'(ov0), 32'd0);
        chk("midrst y",         32'(y0),  32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ov0) seen++;
        end
        chk("midrst no valid", 32'(seen), 32'd0);

        // Reset wins over IN_VALID in the same cycle
        drive(0, 16'd50, 16'd5, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("rst prio in_ready",  32'(ir0), 32'd1);
        chk("rst prio out_valid", 32'(ov0), 32'd0);
        do_op(0, 16'd200, 16'd7, 16'd28, 16'd4, 1'b0, 9, "u8 after rst");

        // Mixed widths 16/4/16
        do_op(2, 16'd1000, 16'd15, 16'd66, 16'd10, 1'b0, 17, "m16 1000/15");
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 4'($urandom_range(0, 15));
            if (rb == 4'd0)
                do_op(2, ra, {12'h0, rb}, 16'hFFFF, ra, 1'b1, 17, "m16 sweep dz");
            else
                do_op(2, ra, {12'h0, rb}, ra / {12'h0, rb}, ra % {12'h0, rb}, 1'b0, 17, "m16 sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
